// File: rtl/bram_bar_zero4k_sdp.sv
// Simple dual-port block RAM for the 4 kB zero-initialised BAR.
// Port A: write-only with byte enables. Port B: read-only, 2-clock latency
// (array read into stage1, then stage1 into doutb).
// The array has no reset so it still maps onto block RAM. Its zero contents
// come from the block RAM power-up value. Only the two port-B pipeline
// registers are cleared by rst_n.
module bram_bar_zero4k_sdp #(
  parameter  int RAM_WIDTH  = 32,
  parameter  int RAM_DEPTH  = 1024,
  localparam int ADDR_WIDTH = $clog2(RAM_DEPTH),
  localparam int WE_WIDTH   = RAM_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] addra,
  input  logic [RAM_WIDTH-1:0]  dina,
  input  logic                  ena,
  input  logic [WE_WIDTH-1:0]   wea,
  input  logic [ADDR_WIDTH-1:0] addrb,
  input  logic                  enb,
  output logic [RAM_WIDTH-1:0]  doutb
);

  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(RAM_DEPTH);

  logic                 wr_in_range;
  logic                 rd_in_range;
  logic [RAM_WIDTH-1:0] rd_word;
  logic [RAM_WIDTH-1:0] stage1_q;
  logic [RAM_WIDTH-1:0] doutb_q;

  // Addresses at or beyond RAM_DEPTH only exist for non-power-of-2 depths.
  assign wr_in_range = ({1'b0, addra} < DEPTH_W);
  assign rd_in_range = ({1'b0, addrb} < DEPTH_W);

  // One narrow array per byte lane keeps each write single-driver.
  for (genvar i = 0; i < WE_WIDTH; i++) begin : g_lane
    logic [7:0] mem_q [RAM_DEPTH];

    // Byte-lane write. Not gated by rst_n.
    always_ff @(posedge clk) begin
      if (ena && wea[i] && wr_in_range) begin
        mem_q[addra] <= dina[8*i +: 8];
      end
    end

    assign rd_word[8*i +: 8] = rd_in_range ? mem_q[addrb] : 8'h00;
  end

  // Port-B pipeline. stage1 samples the array before this edge's write lands,
  // which gives read-first behaviour.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage1_q <= '0;
      doutb_q  <= '0;
    end else begin
      if (enb) begin
        stage1_q <= rd_word;
      end
      doutb_q <= stage1_q;
    end
  end

  assign doutb = doutb_q;

endmodule

// File: tb/tb_bram_bar_zero4k_sdp.sv
// Scoreboard bench for bram_bar_zero4k_sdp. Stimulus pushes the expected doutb
// with the cycle it is due. The monitor pops and compares on falling edges.
module tb_bram_bar_zero4k_sdp;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic [9:0]  addra = '0;
  logic [31:0] dina  = '0;
  logic        ena   = 1'b0;
  logic [3:0]  wea   = '0;
  logic [9:0]  addrb = '0;
  logic        enb   = 1'b0;
  logic [31:0] doutb;

  typedef struct {
    int          due;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  int   cyc    = 0;
  int   n_cmp  = 0;
  int   n_bad  = 0;

  bram_bar_zero4k_sdp dut (
    .clk   (clk),
    .rst_n (rst_n),
    .addra (addra),
    .dina  (dina),
    .ena   (ena),
    .wea   (wea),
    .addrb (addrb),
    .enb   (enb),
    .doutb (doutb)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: doutb=0x%08h required 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void push(input int due, input logic [31:0] exp, input string name);
    exp_t e;
    e.due  = due;
    e.exp  = exp;
    e.name = name;
    sb_q.push_back(e);
  endfunction

  // Monitor: compare every entry that is due on this cycle.
  always @(negedge clk) begin
    while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
      exp_t e;
      e = sb_q.pop_front();
      if (e.due < cyc) begin
        n_cmp++;
        n_bad++;
        $display("FAIL %s: entry due cycle %0d missed, now cycle %0d", e.name, e.due, cyc);
      end else begin
        check(e.name, doutb, e.exp);
      end
    end
  end

  // Drive one cycle of port activity at the falling edge; k is the cycle count then.
  task automatic op(input logic en_a, input logic [3:0] we, input logic [9:0] wa,
                    input logic [31:0] wd, input logic en_b, input logic [9:0] ra,
                    output int k);
    @(negedge clk);
    ena   = en_a;
    wea   = we;
    addra = wa;
    dina  = wd;
    enb   = en_b;
    addrb = ra;
    k     = cyc;
  endtask

  task automatic wr(input logic [9:0] wa, input logic [31:0] wd, input logic [3:0] we);
    int k;
    op(1'b1, we, wa, wd, 1'b0, '0, k);
  endtask

  task automatic rd(input logic [9:0] ra, input logic [31:0] exp, input string name);
    int k;
    op(1'b0, 4'h0, '0, '0, 1'b1, ra, k);
    push(k + 2, exp, name);
  endtask

  task automatic idle();
    int k;
    op(1'b0, 4'h0, '0, '0, 1'b0, '0, k);
  endtask

  initial begin
    int k;
    int budget;

    #1 rst_n = 1'b0;
    #1 check("reset_doutb", doutb, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Power-up zero
    rd(10'h000, 32'h0, "pwrup_000");
    rd(10'h155, 32'h0, "pwrup_155");
    rd(10'h3FF, 32'h0, "pwrup_3ff");
    idle();

    // Full write/readback, including the value one edge early
    wr(10'h010, 32'hDEADBEEF, 4'hF);
    idle();
    op(1'b0, 4'h0, '0, '0, 1'b1, 10'h010, k);
    push(k + 1, 32'h0, "full_not_early");
    push(k + 2, 32'hDEADBEEF, "full_rd");
    idle();

    // Byte enables, then writes with wea=0 and ena=0 must not change the word
    wr(10'h005, 32'h11223344, 4'hF);
    wr(10'h005, 32'hAABBCCDD, 4'h5);
    rd(10'h005, 32'h11BB33DD, "byte_en");
    wr(10'h005, 32'hFFFFFFFF, 4'h0);
    op(1'b0, 4'hF, 10'h005, 32'hFFFFFFFF, 1'b0, '0, k);
    rd(10'h005, 32'h11BB33DD, "no_write");
    idle();

    // Read-first collision
    wr(10'h007, 32'h1, 4'hF);
    op(1'b1, 4'hF, 10'h007, 32'h2, 1'b1, 10'h007, k);
    push(k + 2, 32'h1, "collide_old");
    rd(10'h007, 32'h2, "collide_new");
    idle();

    // Pipeline and enb hold
    wr(10'h001, 32'hA, 4'hF);
    wr(10'h002, 32'hB, 4'hF);
    rd(10'h001, 32'hA, "pipe_a");
    rd(10'h002, 32'hB, "pipe_b");
    op(1'b0, 4'h0, '0, '0, 1'b0, '0, k);
    push(k + 2, 32'hB, "hold_1");
    op(1'b0, 4'h0, '0, '0, 1'b0, '0, k);
    push(k + 2, 32'hB, "hold_2");

    // Different-address write and read on one edge
    op(1'b1, 4'hF, 10'h003, 32'h33, 1'b1, 10'h010, k);
    push(k + 2, 32'hDEADBEEF, "indep_rd");
    rd(10'h003, 32'h33, "indep_wr");

    // Stream reads, then async reset mid-cycle
    for (int i = 0; i < 4; i++) rd(10'h010, 32'hDEADBEEF, "stream");
    op(1'b0, 4'h0, '0, '0, 1'b1, 10'h010, k);
    op(1'b0, 4'h0, '0, '0, 1'b1, 10'h010, k);
    #2 rst_n = 1'b0;
    #1 check("async_rst", doutb, 32'h0);
    op(1'b1, 4'hF, 10'h020, 32'h12345678, 1'b1, 10'h010, k);
    @(posedge clk);
    #1 check("rst_hold_1", doutb, 32'h0);
    @(posedge clk);
    #1 check("rst_hold_2", doutb, 32'h0);
    @(negedge clk);
    ena   = 1'b0;
    wea   = 4'h0;
    enb   = 1'b0;
    rst_n = 1'b1;
    k     = cyc;
    push(k + 1, 32'h0, "stage1_cleared");
    rd(10'h010, 32'hDEADBEEF, "post_rst_keep");
    rd(10'h020, 32'h12345678, "wr_during_rst");
    idle();

    budget = 0;
    while (sb_q.size() > 0 && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    if (sb_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: %0d entries left, required 0", sb_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
